// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the mini-SRC datapath/memory.
// Handshake: the sequencer raises mem_read or mem_write and holds it, together
// with its companion strobes, every cycle until it samples mem_ready=1 at a
// rising clock edge; that edge completes the access and the next step begins.
// mem_ready is only looked at while a request strobe is high.
interface control_sequencer_if #(
    parameter int DATA_W = 32
);
    // datapath/memory to sequencer
    logic [DATA_W-1:0] ir;
    logic              con_ff;
    logic              mem_ready;
    logic              start;

    // sequencer to datapath/memory
    logic pco, pci, pc_inc;
    logic mari, mdri, mdro;
    logic mem_read, mem_write;
    logic iri, coni;
    logic gra, grb, grc;
    logic rin, rout, baout;
    logic ryi, rzi, rzlo, rzho;
    logic hii, hio, loi, loo;
    logic ipo, opi, csigno;
    logic [4:0] op_select;
    logic running, fault, illegal;

    // FSM visibility: encoded state and execute step
    logic [2:0] dbg_state;
    logic [2:0] dbg_step;

    modport master (
        input  ir, con_ff, mem_ready, start,
        output pco, pci, pc_inc, mari, mdri, mdro, mem_read, mem_write,
               iri, coni, gra, grb, grc, rin, rout, baout,
               ryi, rzi, rzlo, rzho, hii, hio, loi, loo,
               ipo, opi, csigno, op_select, running, fault, illegal,
               dbg_state, dbg_step
    );

    modport slave (
        output ir, con_ff, mem_ready, start,
        input  pco, pci, pc_inc, mari, mdri, mdro, mem_read, mem_write,
               iri, coni, gra, grb, grc, rin, rout, baout,
               ryi, rzi, rzlo, rzho, hii, hio, loi, loo,
               ipo, opi, csigno, op_select, running, fault, illegal,
               dbg_state, dbg_step
    );
endinterface

// File: rtl/control_sequencer.sv
// Fetch/decode/execute control unit for the mini-SRC datapath. One state or
// execute step per clock; memory steps stretch until mem_ready, with an
// optional timeout that halts the machine and raises a sticky fault.
// All strobes are decoded from the registered state/step, so an asynchronous
// reset removes them immediately.
module control_sequencer #(
    parameter int DATA_W      = 32,
    parameter int OPC_LSB     = 27,
    parameter int MEM_TIMEOUT = 15,
    parameter int RESET_RUN   = 1
) (
    input logic                 clock,
    input logic                 reset_n,
    control_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH0 = 3'd1,
        S_FETCH1 = 3'd2,
        S_FETCH2 = 3'd3,
        S_EXEC   = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t           r_state, w_next_state;
    logic [2:0]       r_step, w_next_step;
    logic             r_fault, w_set_fault;
    logic [CNT_W-1:0] r_wait_cnt;

    logic [4:0] w_opc;
    logic       w_is_ld, w_is_ldi, w_is_st, w_is_mem;
    logic       w_is_alu, w_is_imm, w_is_muldiv, w_is_negnot, w_is_br;
    logic       w_in_wait, w_timeout;
    logic [2:0] w_last_step;
    logic       w_unused_ir;

    assign w_opc       = bus.ir[OPC_LSB+4:OPC_LSB];
    assign w_unused_ir = ^bus.ir;

    assign w_is_ld     = (w_opc == OP_LD);
    assign w_is_ldi    = (w_opc == OP_LDI);
    assign w_is_st     = (w_opc == OP_ST);
    assign w_is_mem    = w_is_ld || w_is_ldi || w_is_st;
    assign w_is_alu    = (w_opc >= 5'b00011) && (w_opc <= 5'b01011);
    assign w_is_imm    = (w_opc >= 5'b01100) && (w_opc <= 5'b01110);
    assign w_is_muldiv = (w_opc == 5'b01111) || (w_opc == 5'b10000);
    assign w_is_negnot = (w_opc == 5'b10001) || (w_opc == 5'b10010);
    assign w_is_br     = (w_opc == 5'b10011);

    // A wait step is any step that holds a memory request strobe.
    assign w_in_wait = (r_state == S_FETCH1) ||
                       ((r_state == S_EXEC) &&
                        ((w_is_ld && (r_step == 3'd6)) || (w_is_st && (r_step == 3'd7))));

    // The cycle in which the MEM_TIMEOUT-th consecutive not-ready sample is taken.
    assign w_timeout = (MEM_TIMEOUT != 0) && w_in_wait && !bus.mem_ready &&
                       (int'(r_wait_cnt) == MEM_TIMEOUT - 1);

    // Final execute step for the instruction currently in IR.
    always_comb begin : last_step_decode
        w_last_step = 3'd3;
        if (w_is_ld || w_is_st)                       w_last_step = 3'd7;
        else if (w_is_ldi || w_is_alu || w_is_imm)    w_last_step = 3'd5;
        else if (w_is_muldiv || w_is_br)              w_last_step = 3'd6;
        else if (w_is_negnot || (w_opc == OP_JAL))    w_last_step = 3'd4;
    end

    // State and step register; reset parks the machine in RESET.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RESET;
            r_step  <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_step  <= w_next_step;
        end
    end

    // Sticky timeout fault; only reset clears it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)         r_fault <= 1'b0;
        else if (w_set_fault) r_fault <= 1'b1;
    end

    // Counts not-ready cycles inside a wait step; zero everywhere else.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                                       r_wait_cnt <= '0;
        else if (w_in_wait && !bus.mem_ready && !w_timeout) r_wait_cnt <= r_wait_cnt + 1'b1;
        else                                                r_wait_cnt <= '0;
    end

    // Next state/step sequencing.
    always_comb begin : next_state_decode
        w_next_state = r_state;
        w_next_step  = 3'd0;
        w_set_fault  = 1'b0;
        case (r_state)
            S_RESET:  w_next_state = (RESET_RUN != 0) ? S_FETCH0 : S_HALTED;
            S_FETCH0: w_next_state = S_FETCH1;
            S_FETCH1: begin
                if (bus.mem_ready) begin
                    w_next_state = S_FETCH2;
                end else if (w_timeout) begin
                    w_next_state = S_HALTED;
                    w_set_fault  = 1'b1;
                end
            end
            S_FETCH2: begin
                w_next_state = S_EXEC;
                w_next_step  = 3'd3;
            end
            S_EXEC: begin
                w_next_step = r_step;
                if (w_in_wait && !bus.mem_ready) begin
                    if (w_timeout) begin
                        w_next_state = S_HALTED;
                        w_next_step  = 3'd0;
                        w_set_fault  = 1'b1;
                    end
                end else if ((w_opc == OP_HALT) && (r_step == 3'd3)) begin
                    w_next_state = S_HALTED;
                    w_next_step  = 3'd0;
                end else if (r_step == w_last_step) begin
                    w_next_state = S_FETCH0;
                    w_next_step  = 3'd0;
                end else begin
                    w_next_step = r_step + 3'd1;
                end
            end
            S_HALTED: if (bus.start && !r_fault) w_next_state = S_FETCH0;
            default:  w_next_state = S_RESET;
        endcase
    end

    // Moore strobe decode from state, step and opcode.
    always_comb begin : strobe_decode
        bus.pco = 1'b0;  bus.pci = 1'b0;  bus.pc_inc = 1'b0;
        bus.mari = 1'b0; bus.mdri = 1'b0; bus.mdro = 1'b0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.iri = 1'b0;  bus.coni = 1'b0;
        bus.gra = 1'b0;  bus.grb = 1'b0;  bus.grc = 1'b0;
        bus.rin = 1'b0;  bus.rout = 1'b0; bus.baout = 1'b0;
        bus.ryi = 1'b0;  bus.rzi = 1'b0;  bus.rzlo = 1'b0; bus.rzho = 1'b0;
        bus.hii = 1'b0;  bus.hio = 1'b0;  bus.loi = 1'b0;  bus.loo = 1'b0;
        bus.ipo = 1'b0;  bus.opi = 1'b0;  bus.csigno = 1'b0;
        bus.op_select = 5'b00000;
        bus.illegal   = 1'b0;
        bus.fault     = r_fault;
        bus.running   = (r_state != S_RESET) && (r_state != S_HALTED);
        case (r_state)
            S_FETCH0: begin bus.pco = 1'b1; bus.mari = 1'b1; bus.pc_inc = 1'b1; end
            S_FETCH1: begin bus.mem_read = 1'b1; bus.mdri = 1'b1; end
            S_FETCH2: begin bus.mdro = 1'b1; bus.iri = 1'b1; end
            S_EXEC: begin
                if (w_is_mem) begin
                    case (r_step)
                        3'd3: begin bus.grb = 1'b1; bus.baout = 1'b1; bus.ryi = 1'b1; end
                        3'd4: begin bus.csigno = 1'b1; bus.rzi = 1'b1; bus.op_select = OP_ADD; end
                        3'd5: begin
                            bus.rzlo = 1'b1;
                            if (w_is_ldi) begin bus.gra = 1'b1; bus.rin = 1'b1; end
                            else          bus.mari = 1'b1;
                        end
                        3'd6: begin
                            bus.mdri = 1'b1;
                            if (w_is_ld) bus.mem_read = 1'b1;
                            else begin bus.gra = 1'b1; bus.rout = 1'b1; end
                        end
                        3'd7: begin
                            if (w_is_ld) begin bus.mdro = 1'b1; bus.gra = 1'b1; bus.rin = 1'b1; end
                            else         bus.mem_write = 1'b1;
                        end
                        default: ;
                    endcase
                end else if (w_is_alu || w_is_imm) begin
                    case (r_step)
                        3'd3: begin bus.grb = 1'b1; bus.rout = 1'b1; bus.ryi = 1'b1; end
                        3'd4: begin
                            bus.rzi = 1'b1;
                            bus.op_select = w_opc;
                            if (w_is_alu) begin bus.grc = 1'b1; bus.rout = 1'b1; end
                            else          bus.csigno = 1'b1;
                        end
                        3'd5: begin bus.rzlo = 1'b1; bus.gra = 1'b1; bus.rin = 1'b1; end
                        default: ;
                    endcase
                end else if (w_is_muldiv) begin
                    case (r_step)
                        3'd3: begin bus.gra = 1'b1; bus.rout = 1'b1; bus.ryi = 1'b1; end
                        3'd4: begin bus.grb = 1'b1; bus.rout = 1'b1; bus.rzi = 1'b1; bus.op_select = w_opc; end
                        3'd5: begin bus.rzlo = 1'b1; bus.loi = 1'b1; end
                        3'd6: begin bus.rzho = 1'b1; bus.hii = 1'b1; end
                        default: ;
                    endcase
                end else if (w_is_negnot) begin
                    case (r_step)
                        3'd3: begin bus.grb = 1'b1; bus.rout = 1'b1; bus.rzi = 1'b1; bus.op_select = w_opc; end
                        3'd4: begin bus.rzlo = 1'b1; bus.gra = 1'b1; bus.rin = 1'b1; end
                        default: ;
                    endcase
                end else if (w_is_br) begin
                    case (r_step)
                        3'd3: begin bus.gra = 1'b1; bus.rout = 1'b1; bus.coni = 1'b1; end
                        3'd4: begin bus.pco = 1'b1; bus.ryi = 1'b1; end
                        3'd5: begin bus.csigno = 1'b1; bus.rzi = 1'b1; bus.op_select = OP_ADD; end
                        3'd6: if (bus.con_ff) begin bus.rzlo = 1'b1; bus.pci = 1'b1; end
                        default: ;
                    endcase
                end else begin
                    case (w_opc)
                        OP_JR:   if (r_step == 3'd3) begin bus.gra = 1'b1; bus.rout = 1'b1; bus.pci = 1'b1; end
                        OP_JAL: begin
                            if (r_step == 3'd3) begin bus.pco = 1'b1; bus.grb = 1'b1; bus.rin = 1'b1; end
                            if (r_step == 3'd4) begin bus.gra = 1'b1; bus.rout = 1'b1; bus.pci = 1'b1; end
                        end
                        OP_IN:   begin bus.ipo = 1'b1; bus.gra = 1'b1; bus.rin = 1'b1; end
                        OP_OUT:  begin bus.gra = 1'b1; bus.rout = 1'b1; bus.opi = 1'b1; end
                        OP_MFHI: begin bus.hio = 1'b1; bus.gra = 1'b1; bus.rin = 1'b1; end
                        OP_MFLO: begin bus.loo = 1'b1; bus.gra = 1'b1; bus.rin = 1'b1; end
                        default: bus.illegal = (w_opc[4:2] == 3'b111);
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign bus.dbg_state = r_state;
    assign bus.dbg_step  = r_step;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: every observed cycle is compared
// against a queue of expected strobe vectors built by the stimulus steps.
module tb_control_sequencer;

    localparam int W = 35;

    // observation vector bit positions
    localparam logic [W-1:0] PCO    = W'(1) << 0;
    localparam logic [W-1:0] PCI    = W'(1) << 1;
    localparam logic [W-1:0] PCINC  = W'(1) << 2;
    localparam logic [W-1:0] MARI   = W'(1) << 3;
    localparam logic [W-1:0] MDRI   = W'(1) << 4;
    localparam logic [W-1:0] MDRO   = W'(1) << 5;
    localparam logic [W-1:0] MRD    = W'(1) << 6;
    localparam logic [W-1:0] MWR    = W'(1) << 7;
    localparam logic [W-1:0] IRI    = W'(1) << 8;
    localparam logic [W-1:0] CONI   = W'(1) << 9;
    localparam logic [W-1:0] GRA    = W'(1) << 10;
    localparam logic [W-1:0] GRB    = W'(1) << 11;
    localparam logic [W-1:0] GRC    = W'(1) << 12;
    localparam logic [W-1:0] RIN    = W'(1) << 13;
    localparam logic [W-1:0] ROUT   = W'(1) << 14;
    localparam logic [W-1:0] BAOUT  = W'(1) << 15;
    localparam logic [W-1:0] RYI    = W'(1) << 16;
    localparam logic [W-1:0] RZI    = W'(1) << 17;
    localparam logic [W-1:0] RZLO   = W'(1) << 18;
    localparam logic [W-1:0] RZHO   = W'(1) << 19;
    localparam logic [W-1:0] HII    = W'(1) << 20;
    localparam logic [W-1:0] HIO    = W'(1) << 21;
    localparam logic [W-1:0] LOI    = W'(1) << 22;
    localparam logic [W-1:0] LOO    = W'(1) << 23;
    localparam logic [W-1:0] IPO    = W'(1) << 24;
    localparam logic [W-1:0] OPI    = W'(1) << 25;
    localparam logic [W-1:0] CSIGNO = W'(1) << 26;
    localparam logic [W-1:0] RUN    = W'(1) << 27;
    localparam logic [W-1:0] FLT    = W'(1) << 28;
    localparam logic [W-1:0] ILL    = W'(1) << 29;

    localparam logic [W-1:0] F0 = PCO | MARI | PCINC | RUN;
    localparam logic [W-1:0] F1 = MRD | MDRI | RUN;
    localparam logic [W-1:0] F2 = MDRO | IRI | RUN;

    logic clock;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] exp_q[$];
    logic         mr_q[$];
    logic [W-1:0] obs;

    control_sequencer_if #(.DATA_W(32)) bus ();

    control_sequencer #(
        .DATA_W(32), .OPC_LSB(27), .MEM_TIMEOUT(15), .RESET_RUN(1)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign obs = {bus.op_select, bus.illegal, bus.fault, bus.running,
                  bus.csigno, bus.opi, bus.ipo, bus.loo, bus.loi, bus.hio, bus.hii,
                  bus.rzho, bus.rzlo, bus.rzi, bus.ryi, bus.baout, bus.rout, bus.rin,
                  bus.grc, bus.grb, bus.gra, bus.coni, bus.iri, bus.mem_write,
                  bus.mem_read, bus.mdro, bus.mdri, bus.mari, bus.pc_inc, bus.pci, bus.pco};

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [W-1:0] ops(input logic [4:0] v);
        return {v, 30'd0};
    endfunction

    function automatic logic [31:0] instr(input logic [4:0] opc);
        return {opc, 27'h0};
    endfunction

    // driver tasks
    task automatic push(input logic [W-1:0] v, input logic mr);
        exp_q.push_back(v);
        mr_q.push_back(mr);
    endtask

    // Pop one expectation per cycle, compare at the falling edge, then apply
    // the mem_ready value the FSM will sample at the following rising edge.
    task automatic run_check(input string tag);
        logic [W-1:0] e;
        int           cyc;
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s cyc%0d observed=%h expected=%h", tag, cyc, obs, e);
            end
            bus.mem_ready = mr_q.pop_front();
            cyc++;
        end
    endtask

    task automatic fetch(input logic [31:0] ir_val, input string tag);
        push(F0, 1'b1);
        run_check({tag, "_f0"});
        bus.ir = ir_val;
        push(F1, 1'b1);
        push(F2, 1'b1);
        run_check({tag, "_f12"});
    endtask

    task automatic check_now(input logic [W-1:0] e, input string tag);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.ir        = '0;
        bus.con_ff    = 1'b0;
        bus.mem_ready = 1'b1;
        bus.start     = 1'b0;

        // reset state
        @(negedge clock);
        @(negedge clock);
        check_now('0, "reset");
        reset_n = 1'b1;

        // add R1,R2,R3
        fetch(32'h18918000, "add");
        push(GRB | ROUT | RYI | RUN, 1'b1);
        push(GRC | ROUT | RZI | ops(5'b00011) | RUN, 1'b1);
        push(RZLO | GRA | RIN | RUN, 1'b1);
        run_check("add_exec");

        // ld with mem_ready low for 4 cycles in T6
        fetch(instr(5'b00000), "ld");
        push(GRB | BAOUT | RYI | RUN, 1'b1);
        push(CSIGNO | RZI | ops(5'b00011) | RUN, 1'b1);
        push(RZLO | MARI | RUN, 1'b0);
        for (int i = 0; i < 4; i++) push(MRD | MDRI | RUN, 1'b0);
        push(MRD | MDRI | RUN, 1'b1);
        push(MDRO | GRA | RIN | RUN, 1'b1);
        run_check("ld_exec");

        // st, memory ready at once
        fetch(instr(5'b00010), "st");
        push(GRB | BAOUT | RYI | RUN, 1'b1);
        push(CSIGNO | RZI | ops(5'b00011) | RUN, 1'b1);
        push(RZLO | MARI | RUN, 1'b1);
        push(GRA | ROUT | MDRI | RUN, 1'b1);
        push(MWR | RUN, 1'b1);
        run_check("st_exec");

        // ldi
        fetch(instr(5'b00001), "ldi");
        push(GRB | BAOUT | RYI | RUN, 1'b1);
        push(CSIGNO | RZI | ops(5'b00011) | RUN, 1'b1);
        push(RZLO | GRA | RIN | RUN, 1'b1);
        run_check("ldi_exec");

        // ori (immediate ALU)
        fetch(instr(5'b01110), "ori");
        push(GRB | ROUT | RYI | RUN, 1'b1);
        push(CSIGNO | RZI | ops(5'b01110) | RUN, 1'b1);
        push(RZLO | GRA | RIN | RUN, 1'b1);
        run_check("ori_exec");

        // div
        fetch(instr(5'b10000), "div");
        push(GRA | ROUT | RYI | RUN, 1'b1);
        push(GRB | ROUT | RZI | ops(5'b10000) | RUN, 1'b1);
        push(RZLO | LOI | RUN, 1'b1);
        push(RZHO | HII | RUN, 1'b1);
        run_check("div_exec");

        // not
        fetch(instr(5'b10010), "not");
        push(GRB | ROUT | RZI | ops(5'b10010) | RUN, 1'b1);
        push(RZLO | GRA | RIN | RUN, 1'b1);
        run_check("not_exec");

        // br not taken / taken
        for (int t = 0; t < 2; t++) begin
            bus.con_ff = (t == 1);
            fetch(instr(5'b10011), "br");
            push(GRA | ROUT | CONI | RUN, 1'b1);
            push(PCO | RYI | RUN, 1'b1);
            push(CSIGNO | RZI | ops(5'b00011) | RUN, 1'b1);
            push(((t == 1) ? (RZLO | PCI) : '0) | RUN, 1'b1);
            run_check((t == 1) ? "br_taken" : "br_not_taken");
        end
        bus.con_ff = 1'b0;

        // jr, jal
        fetch(instr(5'b10100), "jr");
        push(GRA | ROUT | PCI | RUN, 1'b1);
        run_check("jr_exec");
        fetch(instr(5'b10101), "jal");
        push(PCO | GRB | RIN | RUN, 1'b1);
        push(GRA | ROUT | PCI | RUN, 1'b1);
        run_check("jal_exec");

        // single-step I/O and HI/LO moves, nop
        fetch(instr(5'b10110), "in");
        push(IPO | GRA | RIN | RUN, 1'b1);
        run_check("in_exec");
        fetch(instr(5'b10111), "out");
        push(GRA | ROUT | OPI | RUN, 1'b1);
        run_check("out_exec");
        fetch(instr(5'b11000), "mfhi");
        push(HIO | GRA | RIN | RUN, 1'b1);
        run_check("mfhi_exec");
        fetch(instr(5'b11001), "mflo");
        push(LOO | GRA | RIN | RUN, 1'b1);
        run_check("mflo_exec");
        fetch(instr(5'b11010), "nop");
        push(RUN, 1'b1);
        run_check("nop_exec");

        // illegal opcode: one-cycle pulse, then normal fetch
        fetch(instr(5'b11111), "ill");
        push(ILL | RUN, 1'b1);
        run_check("ill_exec");

        // halt, stay halted without start, resume on start
        fetch(instr(5'b11011), "halt");
        push(RUN, 1'b1);
        for (int i = 0; i < 3; i++) push('0, 1'b1);
        run_check("halted");
        bus.start = 1'b1;
        fetch(instr(5'b11010), "resume");
        bus.start = 1'b0;
        push(RUN, 1'b1);
        run_check("resume_nop");

        // async reset in the middle of a fetch wait
        push(F0, 1'b1);
        run_check("abort_f0");
        bus.ir = instr(5'b11010);
        for (int i = 0; i < 3; i++) push(F1, 1'b0);
        run_check("abort_wait");
        #2 reset_n = 1'b0;
        #1 check_now('0, "abort_async");
        @(negedge clock);
        reset_n = 1'b1;
        bus.mem_ready = 1'b1;

        // memory timeout: 15 not-ready cycles, then sticky fault, start ignored
        push(F0, 1'b0);
        run_check("to_f0");
        for (int i = 0; i < 15; i++) push(F1, 1'b0);
        for (int i = 0; i < 2; i++) push(FLT, 1'b0);
        run_check("timeout");
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) push(FLT, 1'b1);
        run_check("fault_start_ignored");
        bus.start = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_now('0, "fault_cleared");
        @(negedge clock);
        reset_n = 1'b1;

        // normal operation after recovery
        fetch(instr(5'b11010), "post_reset");
        push(RUN, 1'b1);
        run_check("post_reset_nop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
